dm_cache_ctrl: RTL and testbench

Parametrised direct-mapped, write-through, write-allocate cache controller that sits between a pipeline memory port (instruction or data side) and the shared multi-cycle main memory. It replaces the single-cycle memory model with a fixed-latency backing store. The block returns hits combinationally, stalls the pipeline on a miss, and refills the line with pipelined word reads. Two instances are used, one for instructions and one for data.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_data_array.sv | 27 ++
 rtl/dm_cache_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped cache controller.
package cache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_words,
                                input int sets);
      return addr_w - 1 - off_w(line_words) - idx_w(sets);
   endfunction

   // Extracts width bits starting at lsb; callers narrow the result.
   function automatic logic [31:0] field(input logic [31:0] addr,
                                         input int lsb, input int width);
      logic [31:0] mask;
      mask = (32'd1 << width) - 32'd1;
      return (addr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/cache_data_array.sv
// Line data storage: one combinational read port, one synchronous write port.
module cache_data_array
   import cache_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int LINE_WORDS = 8,
   parameter int SETS       = 64
) (
   input  logic                         clk,
   input  logic [idx_w(SETS)-1:0]       rd_idx,
   input  logic [off_w(LINE_WORDS)-1:0] rd_off,
   output logic [DATA_W-1:0]            rd_data,
   input  logic                         wr_en,
   input  logic [idx_w(SETS)-1:0]       wr_idx,
   input  logic [off_w(LINE_WORDS)-1:0] wr_off,
   input  logic [DATA_W-1:0]            wr_data
);

   logic [DATA_W-1:0] mem [SETS*LINE_WORDS];

   assign rd_data = mem[{rd_idx, rd_off}];

   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_idx, wr_off}] <= wr_data;
   end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through, write-allocate cache controller with
// combinational hits and pipelined line refill from fixed-latency memory.
module dm_cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int LINE_WORDS = 8,
   parameter int SETS       = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              stall,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS, SETS);
   localparam logic [OFF_W:0]   LW_C   = (OFF_W+1)'(LINE_WORDS);
   localparam logic [OFF_W-1:0] LAST_C = OFF_W'(LINE_WORDS - 1);

   state_t state, state_n;

   logic [OFF_W:0]   issue_cnt, issue_n;
   logic [OFF_W-1:0] recv_cnt, recv_n;
   logic [TAG_W-1:0] tag_q;
   logic [IDX_W-1:0] idx_q;
   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_arr [SETS];
   logic [15:0]      hit_q, miss_q;

   logic [31:0]      addr_ext;
   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             hit;
   logic             miss;
   logic             fill_done;

   logic              stall_c;
   logic              mem_en_c;
   logic              mem_wr_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;

   logic              dwe;
   logic [IDX_W-1:0]  dw_idx;
   logic [OFF_W-1:0]  dw_off;
   logic [DATA_W-1:0] dw_data;
   logic [DATA_W-1:0] rd_data;

   assign addr_ext = 32'(req_addr);
   assign off = OFF_W'(field(addr_ext, 1, OFF_W));
   assign idx = IDX_W'(field(addr_ext, 1 + OFF_W, IDX_W));
   assign tag = TAG_W'(field(addr_ext, 1 + OFF_W + IDX_W, TAG_W));

   assign hit = (state == IDLE) & req_valid & valid_q[idx]
              & (tag_arr[idx] == tag);

   always_comb begin
      state_n     = state;
      issue_n     = issue_cnt;
      recv_n      = recv_cnt;
      stall_c     = 1'b0;
      mem_en_c    = 1'b0;
      mem_wr_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      dwe         = 1'b0;
      dw_idx      = idx;
      dw_off      = off;
      dw_data     = req_wdata;
      miss        = 1'b0;
      fill_done   = 1'b0;
      unique case (state)
         IDLE: begin
            stall_c = req_valid & ~hit;
            if (hit & req_wr) begin
               dwe         = 1'b1;
               mem_en_c    = 1'b1;
               mem_wr_c    = 1'b1;
               mem_addr_c  = req_addr;
               mem_wdata_c = req_wdata;
            end
            if (req_valid & ~hit) begin
               miss    = 1'b1;
               state_n = FILL;
            end
         end
         FILL: begin
            stall_c = 1'b1;
            if (issue_cnt < LW_C) begin
               mem_en_c   = 1'b1;
               mem_addr_c = {tag_q, idx_q, issue_cnt[OFF_W-1:0], 1'b0};
               issue_n    = issue_cnt + (OFF_W+1)'(1);
            end
            // Returns arrive in issue order, so recv_cnt is the word offset.
            if (mem_rvalid) begin
               dwe     = 1'b1;
               dw_idx  = idx_q;
               dw_off  = recv_cnt;
               dw_data = mem_rdata;
               recv_n  = recv_cnt + OFF_W'(1);
               if (recv_cnt == LAST_C) begin
                  fill_done = 1'b1;
                  issue_n   = '0;
                  recv_n    = '0;
                  state_n   = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         valid_q   <= '0;
         hit_q     <= '0;
         miss_q    <= '0;
      end else begin
         state     <= state_n;
         issue_cnt <= issue_n;
         recv_cnt  <= recv_n;
         if (fill_done) valid_q[idx_q] <= 1'b1;
         if (hit) hit_q <= hit_q + 16'd1;
         if (miss) miss_q <= miss_q + 16'd1;
      end
   end

   // Tags are not cleared by reset; the valid bits alone gate them.
   always_ff @(posedge clk) begin
      if (!rst && miss) begin
         tag_q <= tag;
         idx_q <= idx;
      end
      if (!rst && fill_done) tag_arr[idx_q] <= tag_q;
   end

   cache_data_array #(
      .DATA_W    (DATA_W),
      .LINE_WORDS(LINE_WORDS),
      .SETS      (SETS)
   ) u_data (
      .clk    (clk),
      .rd_idx (idx),
      .rd_off (off),
      .rd_data(rd_data),
      .wr_en  (dwe & ~rst),
      .wr_idx (dw_idx),
      .wr_off (dw_off),
      .wr_data(dw_data)
   );

   assign stall      = ~rst & stall_c;
   assign mem_en     = ~rst & mem_en_c;
   assign mem_wr     = ~rst & mem_wr_c;
   assign mem_addr   = rst ? '0 : mem_addr_c;
   assign mem_wdata  = rst ? '0 : mem_wdata_c;
   assign resp_rdata = (hit & ~rst) ? rd_data : '0;
   assign hit_cnt    = rst ? 16'd0 : hit_q;
   assign miss_cnt   = rst ? 16'd0 : miss_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: two configurations against a fixed-latency memory
// and a line-residency reference model.
module tb_dm_cache_ctrl;

   localparam int L0  = 4;
   localparam int L1  = 7;
   localparam int LW0 = 8;
   localparam int S0  = 64;
   localparam int LW1 = 4;
   localparam int S1  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        rst0, v0, wr0, st0, me0, mw0, mrv0;
   logic [15:0] a0, wd0, rd0, ma0, mwd0, mrd0, hc0, mc0;
   logic        rst1, v1, wr1, st1, me1, mw1, mrv1;
   logic [15:0] a1, wd1, rd1, ma1, mwd1, mrd1, hc1, mc1;

   dm_cache_ctrl u0 (
      .clk(clk), .rst(rst0), .req_valid(v0), .req_wr(wr0),
      .req_addr(a0), .req_wdata(wd0), .resp_rdata(rd0), .stall(st0),
      .mem_en(me0), .mem_wr(mw0), .mem_addr(ma0), .mem_wdata(mwd0),
      .mem_rdata(mrd0), .mem_rvalid(mrv0), .hit_cnt(hc0), .miss_cnt(mc0)
   );

   dm_cache_ctrl #(.LINE_WORDS(LW1), .SETS(S1)) u1 (
      .clk(clk), .rst(rst1), .req_valid(v1), .req_wr(wr1),
      .req_addr(a1), .req_wdata(wd1), .resp_rdata(rd1), .stall(st1),
      .mem_en(me1), .mem_wr(mw1), .mem_addr(ma1), .mem_wdata(mwd1),
      .mem_rdata(mrd1), .mem_rvalid(mrv1), .hit_cnt(hc1), .miss_cnt(mc1)
   );

   // Backing store shared by both instances, each with its own latency.
   logic [15:0] mem     [32768];
   logic [15:0] ref_mem [32768];
   logic        p0_v [L0] = '{default: 1'b0};
   logic [15:0] p0_a [L0] = '{default: 16'h0};
   logic        p1_v [L1] = '{default: 1'b0};
   logic [15:0] p1_a [L1] = '{default: 16'h0};

   always @(posedge clk) begin
      if (me0 & mw0) mem[ma0[15:1]] <= mwd0;
      if (me1 & mw1) mem[ma1[15:1]] <= mwd1;
      p0_v[0] <= me0 & ~mw0;
      p0_a[0] <= ma0;
      for (int k = 1; k < L0; k++) begin
         p0_v[k] <= p0_v[k-1];
         p0_a[k] <= p0_a[k-1];
      end
      p1_v[0] <= me1 & ~mw1;
      p1_a[0] <= ma1;
      for (int k = 1; k < L1; k++) begin
         p1_v[k] <= p1_v[k-1];
         p1_a[k] <= p1_a[k-1];
      end
   end

   assign mrv0 = p0_v[L0-1];
   assign mrd0 = mrv0 ? mem[p0_a[L0-1][15:1]] : 16'h0;
   assign mrv1 = p1_v[L1-1];
   assign mrd1 = mrv1 ? mem[p1_a[L1-1][15:1]] : 16'h0;

   int res [2][64];
   int ref_hit [2];
   int ref_miss [2];

   function automatic logic [15:0] pat(input int i);
      return 16'((i * 40503) ^ 'h1357);
   endfunction

   function automatic logic g_st(input int s);
      return (s != 0) ? st1 : st0;
   endfunction
   function automatic logic g_me(input int s);
      return (s != 0) ? me1 : me0;
   endfunction
   function automatic logic g_mw(input int s);
      return (s != 0) ? mw1 : mw0;
   endfunction
   function automatic logic [15:0] g_ma(input int s);
      return (s != 0) ? ma1 : ma0;
   endfunction
   function automatic logic [15:0] g_mwd(input int s);
      return (s != 0) ? mwd1 : mwd0;
   endfunction
   function automatic logic [15:0] g_rd(input int s);
      return (s != 0) ? rd1 : rd0;
   endfunction
   function automatic logic [15:0] g_hc(input int s);
      return (s != 0) ? hc1 : hc0;
   endfunction
   function automatic logic [15:0] g_mc(input int s);
      return (s != 0) ? mc1 : mc0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int s, input logic v, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
      if (s == 0) begin
         v0 = v; wr0 = w; a0 = a; wd0 = d;
      end else begin
         v1 = v; wr1 = w; a1 = a; wd1 = d;
      end
   endtask

   task automatic access(input int s, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic exp_miss,
                         input logic [15:0] exp_rd);
      int lw, lat, n;
      logic [15:0] base;
      logic [15:0] iss [$];
      lw   = (s != 0) ? LW1 : LW0;
      lat  = (s != 0) ? L1 : L0;
      base = a & ~16'(2 * lw - 1);
      @(negedge clk);
      drive(s, 1'b1, w, a, d);
      #1;
      n = 0;
      while (g_st(s) && n < 200) begin
         if (g_me(s) && !g_mw(s)) iss.push_back(g_ma(s));
         @(negedge clk);
         #1;
         n++;
      end
      chk("stall_cycles", n, exp_miss ? lw + lat + 1 : 0);
      if (exp_miss) begin
         chk("fill_issues", iss.size(), lw);
         for (int k = 0; k < iss.size() && k < lw; k++)
            chk("fill_addr", iss[k], 32'(base) + 32'(2 * k));
      end
      if (w) begin
         chk("wt_en_wr", {g_me(s), g_mw(s)}, 2'b11);
         chk("wt_addr", g_ma(s), a);
         chk("wt_data", g_mwd(s), d);
      end else begin
         chk("rdata", g_rd(s), exp_rd);
         chk("load_mem_en", g_me(s), 1'b0);
      end
      ref_hit[s]++;
      if (exp_miss) ref_miss[s]++;
      @(posedge clk);
      #1;
      drive(s, 1'b0, 1'b0, 16'h0, 16'h0);
      if (w) chk("mem_store", mem[a[15:1]], d);
      @(negedge clk);
      chk("idle_mem_en", {g_me(s), g_st(s)}, 2'b00);
      chk("hit_cnt", g_hc(s), 32'(16'(ref_hit[s])));
      chk("miss_cnt", g_mc(s), 32'(16'(ref_miss[s])));
   endtask

   task automatic run(input int s, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic exp_miss,
                      input logic [15:0] exp_rd);
      int lw, sets, line;
      lw   = (s != 0) ? LW1 : LW0;
      sets = (s != 0) ? S1 : S0;
      access(s, w, a, d, exp_miss, exp_rd);
      line = int'(a) / (2 * lw);
      res[s][line % sets] = line;
      if (w) ref_mem[a[15:1]] = d;
   endtask

   task automatic rand_run(input int s);
      int lw, sets, line;
      logic w;
      logic [15:0] a, d;
      lw   = (s != 0) ? LW1 : LW0;
      sets = (s != 0) ? S1 : S0;
      w    = ($urandom_range(0, 3) == 0);
      a    = 16'($urandom_range(0, 16'h03FF)) << 1;
      d    = 16'($urandom);
      line = int'(a) / (2 * lw);
      run(s, w, a, d, res[s][line % sets] != line, ref_mem[a[15:1]]);
   endtask

   typedef struct {
      int          s;
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic        miss;
      logic [15:0] rd;
   } vec_t;

   vec_t tbl [14];

   initial begin
      for (int i = 0; i < 32768; i++) begin
         mem[i]     = pat(i);
         ref_mem[i] = pat(i);
      end
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 64; k++) res[s][k] = -1;
         ref_hit[s]  = 0;
         ref_miss[s] = 0;
      end

      tbl[0]  = '{0, 1'b0, 16'h0040, 16'h0000, 1'b1, pat(16'h0020)};
      tbl[1]  = '{0, 1'b0, 16'h0046, 16'h0000, 1'b0, pat(16'h0023)};
      tbl[2]  = '{0, 1'b1, 16'h0044, 16'hBEEF, 1'b0, 16'h0000};
      tbl[3]  = '{0, 1'b0, 16'h0044, 16'h0000, 1'b0, 16'hBEEF};
      tbl[4]  = '{0, 1'b1, 16'h0440, 16'h1234, 1'b1, 16'h0000};
      tbl[5]  = '{0, 1'b0, 16'h0040, 16'h0000, 1'b1, pat(16'h0020)};
      tbl[6]  = '{0, 1'b0, 16'h0440, 16'h0000, 1'b1, 16'h1234};
      tbl[7]  = '{1, 1'b0, 16'h0000, 16'h0000, 1'b1, pat(16'h0000)};
      tbl[8]  = '{1, 1'b0, 16'hFFFE, 16'h0000, 1'b1, pat(16'h7FFF)};
      tbl[9]  = '{1, 1'b0, 16'h0006, 16'h0000, 1'b0, pat(16'h0003)};
      tbl[10] = '{1, 1'b1, 16'hFFF8, 16'hA5A5, 1'b0, 16'h0000};
      tbl[11] = '{1, 1'b0, 16'h0080, 16'h0000, 1'b1, pat(16'h0040)};
      tbl[12] = '{1, 1'b0, 16'h0000, 16'h0000, 1'b1, pat(16'h0000)};
      tbl[13] = '{1, 1'b0, 16'hFFF8, 16'h0000, 1'b0, 16'hA5A5};

      rst0 = 1'b1;
      rst1 = 1'b1;
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h0040, 16'h0);
      #1;
      chk("rst_outputs", {st0, me0, mw0, ma0, rd0, hc0, mc0}, '0);
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      rst0 = 1'b0;
      rst1 = 1'b0;
      @(negedge clk);
      chk("post_rst_cnt", {hc0, mc0, hc1, mc1}, '0);

      for (int i = 0; i < 14; i++)
         run(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].miss, tbl[i].rd);

      // Reset in the third fill cycle of a miss on 0x0040.
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h0040, 16'h0);
      #1;
      chk("rst_seq_miss", st0, 1'b1);
      repeat (3) @(negedge clk);
      rst0 = 1'b1;
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      #1;
      chk("rst_mid_fill", {st0, me0, ma0, hc0, mc0}, '0);
      @(negedge clk);
      rst0 = 1'b0;
      #1;
      chk("rst_cnt_clear", {hc0, mc0, st0}, '0);
      ref_hit[0]  = 0;
      ref_miss[0] = 0;
      for (int k = 0; k < 64; k++) res[0][k] = -1;
      repeat (10) @(negedge clk);
      chk("stale_rvalid", {st0, me0, hc0, mc0}, '0);
      run(0, 1'b0, 16'h0040, 16'h0, 1'b1, pat(16'h0020));

      for (int i = 0; i < 120; i++) rand_run(0);
      for (int i = 0; i < 120; i++) rand_run(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
